serial_bit_tx: RTL and testbench

//   Serializing transmitter: accepts a parallel word over a valid/ready handshake.

---
 rtl/serial_bit_tx.sv | 156 +++++++++++++++
 tb/tb_serial_bit_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: LSB-first serializer with valid/ready word load and done pulse.
// Optional even-parity bit appended when SERIAL_TX_PARITY_EN is defined.
module serial_bit_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (WIDTH > GAP + 1) ? WIDTH : GAP + 1;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_GAP
    } state_t;

    state_t           state_q,   state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic             serial_q,  serial_d;
    logic             ready_q,   ready_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             word_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q,  parity_d;
`endif

    // Next-state and registered-output logic for the serializer FSM
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        word_end  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                serial_d = 1'b0;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                if (load_valid && ready_q) begin
                    shift_d   = load_data;
                    serial_d  = load_data[0];
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^load_data;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q != BIT_LAST) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    // rotate so bit 1 becomes the next bit on the line
                    shift_d   = {shift_q[0], shift_q[WIDTH-1:1]};
                    serial_d  = shift_q[1];
                end else begin
`ifdef SERIAL_TX_PARITY_EN
                    bit_cnt_d = '0;
                    serial_d  = parity_q;
                    state_d   = S_PARITY;
`else
                    word_end  = 1'b1;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                word_end = 1'b1;
            end
`endif
            S_GAP: begin
                serial_d = 1'b0;
                if (bit_cnt_q == GAP_LAST) begin
                    bit_cnt_d = '0;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // last line bit has completed: pulse done and drop the line
        if (word_end) begin
            done_d    = 1'b1;
            serial_d  = 1'b0;
            bit_cnt_d = '0;
            if (GAP > 0) begin
                state_d = S_GAP;
            end else begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign load_ready = ready_q;
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: checks serial_bit_tx (GAP=1 and GAP=0 instances)
// against a per-cycle word-timeline model plus literal expectations.
module tb_serial_bit_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L  = W + PB + 1;
    localparam int P1 = W + PB + 2;
    localparam int P0 = W + PB + 1;

    typedef struct packed {
        logic s;
        logic d;
        logic r;
        logic b;
    } exp_t;

    logic clock = 1'b0;
    logic reset_b;
    logic lv1, lv0;
    logic [W-1:0] ld1, ld0;
    logic r1, s1, b1, d1;
    logic r0, s0, b0, d0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    serial_bit_tx #(.WIDTH(W), .GAP(1)) dut1 (
        .clock(clock), .reset_b(reset_b),
        .load_valid(lv1), .load_ready(r1), .load_data(ld1),
        .serial_out(s1), .busy(b1), .done(d1)
    );

    serial_bit_tx #(.WIDTH(W), .GAP(0)) dut0 (
        .clock(clock), .reset_b(reset_b),
        .load_valid(lv0), .load_ready(r0), .load_data(ld0),
        .serial_out(s0), .busy(b0), .done(d0)
    );

    function automatic exp_t mk(logic s, logic d, logic r, logic b);
        exp_t e;
        e.s = s; e.d = d; e.r = r; e.b = b;
        return e;
    endfunction

    // expected outputs k cycles after a word was accepted
    function automatic exp_t entry(logic [W-1:0] w, int gap, int k);
        exp_t e;
        e = mk(1'b0, 1'b0, 1'b1, 1'b0);
        if (k < W) e = mk(w[k], 1'b0, 1'b0, 1'b1);
        else if (PB == 1 && k == W) e = mk(^w, 1'b0, 1'b0, 1'b1);
        else if (k == W + PB)
            e = (gap > 0) ? mk(1'b0, 1'b1, 1'b0, 1'b1) : mk(1'b0, 1'b1, 1'b1, 1'b0);
        else if (k < W + PB + gap) e = mk(1'b0, 1'b0, 1'b0, 1'b1);
        return e;
    endfunction

    logic act1 = 1'b0, act0 = 1'b0;
    int k1 = 0, k0 = 0;
    logic [W-1:0] w1 = '0, w0 = '0;
    exp_t e1, e0;

    assign e1 = act1 ? entry(w1, 1, k1) : mk(1'b0, 1'b0, 1'b1, 1'b0);
    assign e0 = act0 ? entry(w0, 0, k0) : mk(1'b0, 1'b0, 1'b1, 1'b0);

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            act1 <= 1'b0; k1 <= 0;
            act0 <= 1'b0; k0 <= 0;
        end else begin
            if (e1.r && lv1) begin
                act1 <= 1'b1; k1 <= 0; w1 <= ld1;
            end else if (act1) begin
                k1 <= k1 + 1;
                if (k1 + 1 >= L) act1 <= 1'b0;
            end
            if (e0.r && lv0) begin
                act0 <= 1'b1; k0 <= 0; w0 <= ld0;
            end else if (act0) begin
                k0 <= k0 + 1;
                if (k0 + 1 >= L) act0 <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(negedge clock) begin
        cyc++;
        tests++;
        if ({s1, d1, r1, b1} !== e1) begin
            fails++;
            $display("FAIL model_gap1 cyc=%0d got sdrb=%b%b%b%b want %b",
                     cyc, s1, d1, r1, b1, e1);
        end
        tests++;
        if ({s0, d0, r0, b0} !== e0) begin
            fails++;
            $display("FAIL model_gap0 cyc=%0d got sdrb=%b%b%b%b want %b",
                     cyc, s0, d0, r0, b0, e0);
        end
    end

    task automatic chk(string n, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    logic cs [0:63];
    logic cd [0:63];
    logic cr [0:63];
    logic cb [0:63];
    logic [0:7] exp_bits;
    int dones;
    int ones;

    initial begin
        reset_b = 1'b1;
        lv1 = 1'b0; lv0 = 1'b0;
        ld1 = '0; ld0 = '0;
        #3 reset_b = 1'b0;
        #1;
        chk("rst_serial", int'(s1), 0);
        chk("rst_ready", int'(r1), 1);
        chk("rst_busy", int'(b1), 0);
        chk("rst_done", int'(d1), 0);
        chk("rst_ready_g0", int'(r0), 1);
        repeat (2) @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);

        // single word 8'hA5
        lv1 = 1'b1; ld1 = 8'hA5;
        for (int c = 0; c < 10 + PB; c++) begin
            @(negedge clock);
            lv1 = 1'b0; ld1 = '0;
            cs[c] = s1; cd[c] = d1; cr[c] = r1;
        end
        exp_bits = 8'b10100101;
        for (int c = 0; c < 8; c++) chk("a5_bit", int'(cs[c]), int'(exp_bits[c]));
        chk("a5_end_serial", int'(cs[8+PB]), 0);
        chk("a5_done", int'(cd[8+PB]), 1);
        chk("a5_ready_low", int'(cr[8+PB]), 0);
        chk("a5_ready_back", int'(cr[9+PB]), 1);

        // busy stall: valid held, data changes to FF after first accept
        lv1 = 1'b1; ld1 = 8'h3C;
        dones = 0; ones = 0;
        for (int c = 0; c < 3 * P1; c++) begin
            @(negedge clock);
            if (c == 0) ld1 = 8'hFF;
            if (c == P1) lv1 = 1'b0;
            dones += int'(d1);
            ones += int'(s1);
        end
        chk("stall_dones", dones, 2);
        chk("stall_ones", ones, 12);

        // reset mid-word
        lv1 = 1'b1; ld1 = 8'hFF;
        @(posedge clock);
        #1 lv1 = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        chk("pre_rst_bit", int'(s1), 1);
        reset_b = 1'b0;
        #1;
        chk("midrst_serial", int'(s1), 0);
        chk("midrst_busy", int'(b1), 0);
        chk("midrst_ready", int'(r1), 1);
        @(negedge clock);
        reset_b = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            dones += int'(d1);
        end
        chk("midrst_no_done", dones, 0);
        lv1 = 1'b1; ld1 = 8'h01;
        for (int c = 0; c < 10 + PB; c++) begin
            @(negedge clock);
            lv1 = 1'b0;
            cs[c] = s1; cd[c] = d1;
        end
        exp_bits = 8'b10000000;
        for (int c = 0; c < 8; c++) chk("w01_bit", int'(cs[c]), int'(exp_bits[c]));
        chk("w01_done", int'(cd[8+PB]), 1);

`ifdef SERIAL_TX_PARITY_EN
        // parity word 8'h07
        lv1 = 1'b1; ld1 = 8'h07;
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            lv1 = 1'b0;
            cs[c] = s1; cd[c] = d1;
        end
        exp_bits = 8'b11100000;
        for (int c = 0; c < 8; c++) chk("p07_bit", int'(cs[c]), int'(exp_bits[c]));
        chk("p07_parity", int'(cs[8]), 1);
        chk("p07_no_early_done", int'(cd[8]), 0);
        chk("p07_done", int'(cd[9]), 1);
`endif

        // back-to-back on the GAP=0 instance
        lv0 = 1'b1; ld0 = 8'h81;
        dones = 0;
        for (int c = 0; c < 3 * P0; c++) begin
            @(negedge clock);
            if (c == 0) ld0 = 8'h3C;
            if (c == P0) lv0 = 1'b0;
            cs[c] = s0; cd[c] = d0; cr[c] = r0; cb[c] = b0;
            dones += int'(d0);
        end
        chk("b2b_first_bit", int'(cs[0]), 1);
        chk("b2b_last_bit", int'(cs[7]), 1);
        chk("b2b_done", int'(cd[8+PB]), 1);
        chk("b2b_ready", int'(cr[8+PB]), 1);
        chk("b2b_w2_bit0", int'(cs[9+PB]), 0);
        chk("b2b_w2_bit2", int'(cs[11+PB]), 1);
        chk("b2b_w2_busy", int'(cb[9+PB]), 1);
        chk("b2b_dones", dones, 2);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
